// File: rtl/dram_rd_arbiter_pkg.sv
// Shared types and AXI constants for the two-requester DRAM read arbiter.
package dram_arb_pkg;

   // Arbiter FSM: pick a requester, issue one burst address, stream its beats.
   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StData
   } arb_state_e;

   localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
   localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
   localparam int unsigned PAGE_BYTES     = 4096;

endpackage

// File: rtl/dram_rd_arbiter_burst_len_calc.sv
// Burst length for the next AXI read: min(MAX_BEATS, words left, words left in the 4 KB page).
// Purely combinational.
module burst_len_calc
   import dram_arb_pkg::*;
#(
   parameter int unsigned MAX_BEATS = 16
) (
   input  logic [9:0] page_word_off,  // address bits [11:2]
   input  logic [8:0] remaining,
   output logic [4:0] burst_len
);

   localparam int unsigned PageWords = PAGE_BYTES / 4;

   logic [10:0] page_words;
   logic [10:0] rem_ext;
   logic [10:0] len;

   // Take the smallest of the three limits; page_words is always 1..1024.
   always_comb begin
      page_words = 11'(PageWords) - {1'b0, page_word_off};
      rem_ext    = {2'b00, remaining};
      len        = 11'(MAX_BEATS);
      if (rem_ext < len) begin
         len = rem_ext;
      end
      if (page_words < len) begin
         len = page_words;
      end
      burst_len = len[4:0];
   end

endmodule

// File: rtl/dram_rd_arbiter.sv
// Two-requester arbiter sharing one AXI4 read port. Requests of 1..256 words are split into
// INCR bursts (<= MAX_BEATS beats, never crossing 4 KB); beats stream back to the granted
// requester with no added latency. The whole request is locked to one requester.
// Optional beat checking (rresp / rid / rlast) is enabled by defining DRAM_RD_ARB_CHECK_EN;
// otherwise err is tied low.
module dram_rd_arbiter
   import dram_arb_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 32,  // must be >= 12
   parameter int unsigned MAX_BEATS  = 16   // must be 1..16, arlen is 4 bits
) (
   input  logic                    clk,
   input  logic                    rst,
   // requester side
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [17:0]             req_words,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic                    rsp_last,
   input  logic [1:0]              rsp_ready,
   output logic                    busy,
   // AXI read address channel
   output logic [ID_WIDTH-1:0]     arid_s_inf,
   output logic [ADDR_WIDTH-1:0]   araddr_s_inf,
   output logic [3:0]              arlen_s_inf,
   output logic [2:0]              arsize_s_inf,
   output logic [1:0]              arburst_s_inf,
   output logic                    arvalid_s_inf,
   input  logic                    arready_s_inf,
   // AXI read data channel
   input  logic [ID_WIDTH-1:0]     rid_s_inf,
   input  logic [DATA_WIDTH-1:0]   rdata_s_inf,
   input  logic [1:0]              rresp_s_inf,
   input  logic                    rlast_s_inf,
   input  logic                    rvalid_s_inf,
   output logic                    rready_s_inf,
   output logic                    err
);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [8:0]            rem_q, rem_d;
   logic [4:0]            beat_q, beat_d;

   logic                  win;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [8:0]            win_words;
   logic [8:0]            win_rem;
   logic [4:0]            burst_len;
   logic                  beat_hs;
   logic                  burst_end;

   burst_len_calc #(
      .MAX_BEATS (MAX_BEATS)
   ) u_burst_len_calc (
      .page_word_off (addr_q[11:2]),
      .remaining     (rem_q),
      .burst_len     (burst_len)
   );

   assign beat_hs   = (state_q == StData) & rvalid_s_inf & rsp_ready[grant_q];
   // Bursts are sequenced from our own beat count, not from rlast.
   assign burst_end = (beat_q == 5'd1);

   // Round-robin pick: on a tie the requester not granted last wins.
   always_comb begin
      if (req_valid == 2'b11) begin
         win = ~last_grant_q;
      end else begin
         win = req_valid[1];
      end
      win_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      win_words = win ? req_words[17:9] : req_words[8:0];
      win_rem   = (win_words == 9'd0) ? 9'd256 : win_words;
   end

   // Next-state logic and request accept.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      beat_d       = beat_q;
      req_ready    = 2'b00;
      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               req_ready[win] = 1'b1;
               grant_d        = win;
               addr_d         = {win_addr[ADDR_WIDTH-1:2], 2'b00};
               rem_d          = win_rem;
               state_d        = StAddr;
            end
         end
         StAddr: begin
            if (arready_s_inf) begin
               beat_d  = burst_len;
               state_d = StData;
            end
         end
         StData: begin
            if (beat_hs) begin
               addr_d = addr_q + ADDR_WIDTH'(4);
               rem_d  = rem_q - 9'd1;
               beat_d = beat_q - 5'd1;
               if (rem_q == 9'd1) begin
                  last_grant_d = grant_q;
                  state_d      = StIdle;
               end else if (burst_end) begin
                  state_d = StAddr;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // AXI and requester-facing outputs; data is a straight passthrough.
   always_comb begin
      arvalid_s_inf = (state_q == StAddr);
      araddr_s_inf  = addr_q;
      arlen_s_inf   = arvalid_s_inf ? 4'(burst_len - 5'd1) : 4'd0;
      arid_s_inf    = '0;
      arid_s_inf[0] = grant_q;
      arsize_s_inf  = AXI_SIZE_4B;
      arburst_s_inf = AXI_BURST_INCR;
      rready_s_inf  = 1'b0;
      rsp_valid     = 2'b00;
      rsp_last      = 1'b0;
      rsp_data      = rdata_s_inf;
      busy          = (state_q != StIdle);
      if (state_q == StData) begin
         rready_s_inf       = rsp_ready[grant_q];
         rsp_valid[grant_q] = rvalid_s_inf;
         rsp_last           = rvalid_s_inf & (rem_q == 9'd1);
      end
   end

   // State registers; last grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         rem_q        <= 9'd0;
         beat_q       <= 5'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         rem_q        <= rem_d;
         beat_q       <= beat_d;
      end
   end

`ifdef DRAM_RD_ARB_CHECK_EN
   logic err_q, err_d;

   // Sticky flag on any bad response, wrong ID or rlast out of step with our beat count.
   always_comb begin
      err_d = err_q;
      if (beat_hs && ((rresp_s_inf != AXI_RESP_OKAY) || (rid_s_inf != arid_s_inf) ||
                      (rlast_s_inf != burst_end))) begin
         err_d = 1'b1;
      end
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic unused_chk;
   assign unused_chk = ^{rid_s_inf, rresp_s_inf, rlast_s_inf};
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Self-checking bench for dram_rd_arbiter: AXI DRAM model, request driver and a scoreboard
// of expected bursts/beats filled when each request is issued.
module tb_dram_rd_arbiter;

`ifdef DRAM_RD_ARB_CHECK_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [63:0] req_addr = '0;
   logic [17:0] req_words = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_last;
   logic [1:0]  rsp_ready = 2'b11;
   logic        busy;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready = 1'b1;
   logic [3:0]  rid = '0;
   logic [31:0] rdata = '0;
   logic [1:0]  rresp = 2'b00;
   logic        rlast = 1'b0;
   logic        rvalid = 1'b0;
   logic        rready;
   logic        err;

   dram_rd_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_words     (req_words),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .rsp_last      (rsp_last),
      .rsp_ready     (rsp_ready),
      .busy          (busy),
      .arid_s_inf    (arid),
      .araddr_s_inf  (araddr),
      .arlen_s_inf   (arlen),
      .arsize_s_inf  (arsize),
      .arburst_s_inf (arburst),
      .arvalid_s_inf (arvalid),
      .arready_s_inf (arready),
      .rid_s_inf     (rid),
      .rdata_s_inf   (rdata),
      .rresp_s_inf   (rresp),
      .rlast_s_inf   (rlast),
      .rvalid_s_inf  (rvalid),
      .rready_s_inf  (rready),
      .err           (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [31:0] addr; logic [3:0] len;} burst_t;
   typedef struct {logic [31:0] data; logic last;} beat_t;
   typedef struct {logic [31:0] addr; logic [3:0] len; logic [3:0] id;} sburst_t;

   burst_t eb0[$], eb1[$];
   beat_t  ed0[$], ed1[$];
   int     grant_log[$], grant_cyc[$], last_cycs[$];
   int     vectors = 0, miscompares = 0;
   int     ar_cnt = 0, rx0 = 0, rx1 = 0, last_cnt = 0;
   int     inj_beat = 0;
   logic   cur_req = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_1F0E;
   endfunction

   function automatic logic sb_empty();
      return (eb0.size() == 0) && (eb1.size() == 0) && (ed0.size() == 0) && (ed1.size() == 0);
   endfunction

   // AXI slave: queues accepted bursts, returns one beat per cycle from mem_word().
   task automatic bg_dram();
      sburst_t sq[$];
      sburst_t nb;
      int      s_beat = 0, s_served = 0;
      logic    ar_hs, r_hs;
      forever begin
         @(negedge clk);
         ar_hs   = arvalid && arready;
         r_hs    = rvalid && rready;
         nb.addr = araddr;
         nb.len  = arlen;
         nb.id   = arid;
         @(posedge clk);
         #1;
         if (rst) begin
            sq.delete();
            s_beat   = 0;
            s_served = 0;
            rvalid   = 1'b0;
            rlast    = 1'b0;
            rresp    = 2'b00;
         end else begin
            if (r_hs && sq.size() > 0) begin
               s_served++;
               if (s_beat == int'(sq[0].len)) begin
                  void'(sq.pop_front());
                  s_beat = 0;
               end else begin
                  s_beat++;
               end
            end
            if (ar_hs) sq.push_back(nb);
            if (sq.size() > 0) begin
               rvalid = 1'b1;
               rdata  = mem_word(sq[0].addr + 32'(4 * s_beat));
               rlast  = (s_beat == int'(sq[0].len));
               rid    = sq[0].id;
               rresp  = (s_served + 1 == inj_beat) ? 2'b10 : 2'b00;
            end else begin
               rvalid = 1'b0;
               rlast  = 1'b0;
               rresp  = 2'b00;
            end
         end
      end
   endtask

   // Drops req_valid once accepted and logs grant order/cycle.
   task automatic bg_req();
      logic [1:0] acc;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (acc != 2'b00) begin
            cur_req = acc[1];
            grant_log.push_back(int'(acc[1]));
            grant_cyc.push_back(cyc);
         end
         @(posedge clk);
         #1;
         req_valid = req_valid & ~acc;
      end
   endtask

   // Scoreboard: pops expected bursts on AR handshakes and expected beats on rsp handshakes.
   task automatic bg_monitor();
      burst_t b;
      beat_t  e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (arvalid && arready) begin
               vectors++;
               ar_cnt++;
               if ((cur_req ? eb1.size() : eb0.size()) == 0) begin
                  miscompares++;
                  $display("FAIL ar_unexpected: got araddr=%h arlen=%0d, no burst expected",
                           araddr, arlen);
               end else begin
                  if (cur_req) b = eb1.pop_front();
                  else b = eb0.pop_front();
                  if (araddr !== b.addr || arlen !== b.len || arid !== {3'b000, cur_req}) begin
                     miscompares++;
                     $display("FAIL ar_burst: got addr=%h len=%0d id=%0d, want addr=%h len=%0d id=%0d",
                              araddr, arlen, arid, b.addr, b.len, cur_req);
                  end
               end
            end
            if (rsp_valid != 2'b00) begin
               vectors++;
               if (rsp_valid !== (2'b01 << cur_req)) begin
                  miscompares++;
                  $display("FAIL rsp_valid_route: got %b, want %b", rsp_valid, 2'b01 << cur_req);
               end
            end
            if (rsp_valid[cur_req] && rsp_ready[cur_req]) begin
               vectors++;
               if (cur_req) rx1++;
               else rx0++;
               if (rsp_last) begin
                  last_cnt++;
                  last_cycs.push_back(cyc);
               end
               if ((cur_req ? ed1.size() : ed0.size()) == 0) begin
                  miscompares++;
                  $display("FAIL beat_unexpected: got data=%h, no beat expected", rsp_data);
               end else begin
                  if (cur_req) e = ed1.pop_front();
                  else e = ed0.pop_front();
                  if (rsp_data !== e.data || rsp_last !== e.last) begin
                     miscompares++;
                     $display("FAIL beat: got data=%h last=%b, want data=%h last=%b",
                              rsp_data, rsp_last, e.data, e.last);
                  end
               end
            end
            if (req_ready != 2'b00) begin
               vectors++;
               if (busy || req_ready == 2'b11 || (req_ready & ~req_valid) != 2'b00) begin
                  miscompares++;
                  $display("FAIL req_ready: got %b (busy=%b valid=%b), want one-hot subset of valid in idle",
                           req_ready, busy, req_valid);
               end
            end
         end
      end
   endtask

   // Loads the scoreboard with the bursts/beats a request should produce, then raises req_valid.
   task automatic issue(input int r, input logic [31:0] addr, input logic [8:0] words);
      logic [31:0] a;
      int          rem, page, len;
      burst_t      b;
      beat_t       e;
      a   = addr & ~32'h3;
      rem = (words == 9'd0) ? 256 : int'(words);
      while (rem > 0) begin
         page = (4096 - int'(a[11:0])) / 4;
         len  = 16;
         if (rem < len) len = rem;
         if (page < len) len = page;
         b.addr = a;
         b.len  = 4'(len - 1);
         if (r == 0) eb0.push_back(b);
         else eb1.push_back(b);
         for (int i = 0; i < len; i++) begin
            e.data = mem_word(a + 32'(4 * i));
            e.last = (rem - i == 1);
            if (r == 0) ed0.push_back(e);
            else ed1.push_back(e);
         end
         a   = a + 32'(4 * len);
         rem = rem - len;
      end
      req_addr[r*32 +: 32] = addr;
      req_words[r*9 +: 9]  = words;
      req_valid[r]         = 1'b1;
   endtask

   task automatic wait_idle(input int budget);
      int   n = 0;
      logic idle = 1'b0;
      while (!idle && n < budget) begin
         @(negedge clk);
         n++;
         idle = sb_empty() && !busy && (req_valid == 2'b00);
      end
      vectors++;
      if (!idle) begin
         miscompares++;
         $display("FAIL wait_idle: got busy after %0d cycles, want idle", n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      ar_cnt   = 0;
      rx0      = 0;
      rx1      = 0;
      last_cnt = 0;
      grant_log.delete();
      grant_cyc.delete();
      last_cycs.delete();
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors += 10;
      if (req_ready !== 2'b00) begin miscompares++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
      if (rsp_valid !== 2'b00) begin miscompares++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
      if (rsp_last !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_last: got %b want 0", rsp_last); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (arvalid !== 1'b0) begin miscompares++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
      if (rready !== 1'b0) begin miscompares++; $display("FAIL rst_rready: got %b want 0", rready); end
      if (araddr !== 32'h0) begin miscompares++; $display("FAIL rst_araddr: got %h want 0", araddr); end
      if (arlen !== 4'h0) begin miscompares++; $display("FAIL rst_arlen: got %h want 0", arlen); end
      if (arid !== 4'h0) begin miscompares++; $display("FAIL rst_arid: got %h want 0", arid); end
      if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      vectors += 2;
      if (arsize !== 3'b010) begin miscompares++; $display("FAIL arsize: got %b want 010", arsize); end
      if (arburst !== 2'b01) begin miscompares++; $display("FAIL arburst: got %b want 01", arburst); end
   endtask

   task automatic test_tie();
      clear_counts();
      issue(0, 32'h0000_2000, 9'd8);
      issue(1, 32'h0000_3000, 9'd4);
      wait_idle(400);
      issue(0, 32'h2000_0F00, 9'd0);
      issue(1, 32'h0000_4004, 9'd3);
      wait_idle(1000);
      vectors++;
      if (grant_log.size() != 4) begin
         miscompares++;
         $display("FAIL tie_grant_count: got %0d grants want 4", grant_log.size());
      end else begin
         vectors++;
         if (grant_log[0] != 0 || grant_log[1] != 1 || grant_log[2] != 0 || grant_log[3] != 1) begin
            miscompares++;
            $display("FAIL tie_order: got %0d%0d%0d%0d want 0101",
                     grant_log[0], grant_log[1], grant_log[2], grant_log[3]);
         end
         vectors++;
         if (last_cycs.size() == 0 || grant_cyc[1] != last_cycs[0] + 1) begin
            miscompares++;
            $display("FAIL tie_regrant_cycle: got cycle %0d want one after last beat", grant_cyc[1]);
         end
      end
      vectors++;
      if (rx0 != 264 || rx1 != 7) begin
         miscompares++;
         $display("FAIL tie_beats: got rx0=%0d rx1=%0d want 264 7", rx0, rx1);
      end
   endtask

   task automatic test_long();
      clear_counts();
      issue(0, 32'h0001_0000, 9'd256);
      wait_idle(1000);
      vectors++;
      if (ar_cnt != 16 || rx0 != 256 || last_cnt != 1) begin
         miscompares++;
         $display("FAIL long: got bursts=%0d beats=%0d lasts=%0d want 16 256 1", ar_cnt, rx0, last_cnt);
      end
   endtask

   task automatic test_split();
      int n = 0;
      clear_counts();
      arready = 1'b0;
      issue(1, 32'h0000_0FF8, 9'd5);
      while (!arvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         vectors++;
         if (arvalid !== 1'b1 || araddr !== 32'h0000_0FF8 || arlen !== 4'd1) begin
            miscompares++;
            $display("FAIL split_hold: got arvalid=%b addr=%h len=%0d want 1 00000ff8 1",
                     arvalid, araddr, arlen);
         end
      end
      @(posedge clk);
      #1 arready = 1'b1;
      wait_idle(200);
      vectors++;
      if (ar_cnt != 2 || rx1 != 5) begin
         miscompares++;
         $display("FAIL split: got bursts=%0d beats=%0d want 2 5", ar_cnt, rx1);
      end
   endtask

   task automatic test_backpressure();
      logic done = 1'b0;
      clear_counts();
      issue(0, 32'h0000_8000, 9'd16);
      for (int n = 0; n < 300 && !done; n++) begin
         @(posedge clk);
         #1 rsp_ready[0] = ~rsp_ready[0];
         @(negedge clk);
         if (rsp_valid[0]) begin
            vectors++;
            if (rready !== rsp_ready[0]) begin
               miscompares++;
               $display("FAIL bp_rready: got %b want %b", rready, rsp_ready[0]);
            end
         end
         done = sb_empty() && !busy && (req_valid == 2'b00);
      end
      rsp_ready = 2'b11;
      vectors++;
      if (!done || rx0 != 16) begin
         miscompares++;
         $display("FAIL bp_done: got done=%b beats=%0d want 1 16", done, rx0);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset();
      int n = 0;
      clear_counts();
      issue(0, 32'h0000_0300, 9'd16);
      while (rx0 < 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (arvalid !== 1'b0 || rready !== 1'b0 || busy !== 1'b0 || rsp_valid !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst: got arvalid=%b rready=%b busy=%b rsp_valid=%b want all 0",
                  arvalid, rready, busy, rsp_valid);
      end
      eb0.delete();
      eb1.delete();
      ed0.delete();
      ed1.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      clear_counts();
      issue(1, 32'h0000_0500, 9'd7);
      wait_idle(200);
      vectors++;
      if (rx1 != 7 || last_cnt != 1) begin
         miscompares++;
         $display("FAIL midrst_after: got beats=%0d lasts=%0d want 7 1", rx1, last_cnt);
      end
   endtask

   task automatic test_err();
      clear_counts();
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_before: got %b want 0", err);
      end
      inj_beat = 3;
      issue(0, 32'h0000_9000, 9'd6);
      wait_idle(200);
      inj_beat = 0;
      vectors++;
      if (err !== EXP_ERR) begin
         miscompares++;
         $display("FAIL err_set: got %b want %b", err, EXP_ERR);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      vectors++;
      if (err !== EXP_ERR) begin
         miscompares++;
         $display("FAIL err_sticky: got %b want %b", err, EXP_ERR);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (err !== 1'b0) begin
         miscompares++;
         $display("FAIL err_clear: got %b want 0", err);
      end
      @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         bg_dram();
         bg_req();
         bg_monitor();
      join_none
      test_reset();
      test_tie();
      test_long();
      test_split();
      test_backpressure();
      test_mid_reset();
      test_err();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish by 500000, want earlier finish");
      $fatal(1, "watchdog");
   end

endmodule
